// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/done handshake and operand/result bundle for serial_subtractor (optional sub port under SERIAL_SUBTRACTOR_ADD_MODE_EN)
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             b_in;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             b_out;

`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
  modport master (output start, x, y, b_in, sub, input busy, done, diff, b_out);
  modport slave  (input start, x, y, b_in, sub, output busy, done, diff, b_out);
`else
  modport master (output start, x, y, b_in, input busy, done, diff, b_out);
  modport slave  (input start, x, y, b_in, output busy, done, diff, b_out);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first subtractor diff = x - y - b_in; SERIAL_SUBTRACTOR_ADD_MODE_EN adds a runtime add mode
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input logic               clk,
  input logic               rst,
  serial_subtractor_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] xr_q, xr_d;
  logic [WIDTH-1:0] yr_q, yr_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             b_out_q, b_out_d;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
  logic             sub_q, sub_d;
`endif

  logic             d_bit;
  logic             br_next;

  // State register: every flop, synchronous reset to the documented idle values
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      xr_q    <= '0;
      yr_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      diff_q  <= '0;
      b_out_q <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      xr_q    <= xr_d;
      yr_q    <= yr_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      diff_q  <= diff_d;
      b_out_q <= b_out_d;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
      sub_q   <= sub_d;
`endif
    end
  end

  // Single full-subtractor (or full-adder in add mode) cell on the operand LSBs
  always_comb begin
    d_bit = xr_q[0] ^ yr_q[0] ^ br_q;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    if (sub_q) begin
      br_next = (~xr_q[0] & yr_q[0]) | (~(xr_q[0] ^ yr_q[0]) & br_q);
    end else begin
      br_next = (xr_q[0] & yr_q[0]) | (xr_q[0] & br_q) | (yr_q[0] & br_q);
    end
`else
    br_next = (~xr_q[0] & yr_q[0]) | (~(xr_q[0] ^ yr_q[0]) & br_q);
`endif
  end

  // Next-state and datapath: capture in IDLE, shift W times, publish result on the last shift
  always_comb begin
    state_d = state_q;
    xr_d    = xr_q;
    yr_d    = yr_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    diff_d  = diff_q;
    b_out_d = b_out_q;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_SHIFT;
          xr_d    = bus.x;
          yr_d    = bus.y;
          br_d    = bus.b_in;
          cnt_d   = '0;
          acc_d   = '0;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
          sub_d   = bus.sub;
`endif
        end
      end
      S_SHIFT: begin
        br_d  = br_next;
        acc_d = {d_bit, acc_q[WIDTH-1:1]};
        xr_d  = {1'b0, xr_q[WIDTH-1:1]};
        yr_d  = {1'b0, yr_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        // Only the final shift updates diff, so partial sums never leak out
        if (cnt_q == CW'(WIDTH - 1)) begin
          diff_d  = {d_bit, acc_q[WIDTH-1:1]};
          b_out_d = br_next;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs: status decoded from state, results straight from their flops
  always_comb begin
    bus.busy  = (state_q != S_IDLE);
    bus.done  = (state_q == S_DONE);
    bus.diff  = diff_q;
    bus.b_out = b_out_q;
  end

endmodule
